pea_tile_sched: RTL and testbench

//  Next-generation PE-array sequencer: walks an output feature map tile by tile, with loop order

---
 rtl/pea_tile_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_pea_tile_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_tile_sched.sv
// pea_tile_sched: tiled PE-array sequencer (pixel-col -> ic -> oc -> tile-col -> tile-row).
// Define PEA_TILE_SCHED_PERF_EN to build the busy/stall performance counters.
module pea_tile_sched #(
    parameter int unsigned TILE_LEN      = 16,
    parameter int unsigned TILE_ROWS     = 8,
    parameter int unsigned CHN_WIDTH     = 4,
    parameter int unsigned CHN_OFT_WIDTH = 6,
    parameter int unsigned FMS_WIDTH     = 8,
    parameter int unsigned FLUSH_LAT     = 5,
    parameter int unsigned PV_LAT        = 3,
    parameter int unsigned PERF_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CHN_WIDTH-1:0]  chi,
    input  logic [CHN_WIDTH-1:0]  cho,
    input  logic                  stride,
    input  logic                  ksize,
    input  logic [FMS_WIDTH-1:0]  ifm_size,
    input  logic                  start_conv,
    input  logic                  abort,
    input  logic                  out_ready,
    output logic                  ifm_read,
    output logic                  wgt_read,
    output logic                  pvalid,
    output logic                  ic_done,
    output logic                  oc_done,
    output logic                  tile_done,
    output logic                  conv_done,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [PERF_WIDTH-1:0] perf_cycles,
    output logic [PERF_WIDTH-1:0] perf_stalls
);

    localparam int unsigned TL_LG = $clog2(TILE_LEN);
    localparam int unsigned TR_LG = $clog2(TILE_ROWS);
    localparam int unsigned PCW   = TL_LG + 1;
    localparam int unsigned ICW   = CHN_WIDTH + CHN_OFT_WIDTH;
    localparam int unsigned FCW   = $clog2(FLUSH_LAT + 1);
    localparam int unsigned FW    = FMS_WIDTH;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_CALC = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [FCW-1:0]       fc_q, fc_d;
    logic [PCW-1:0]       pc_q, pc_d;
    logic [ICW-1:0]       ic_q, ic_d, oc_q, oc_d;
    logic [FW-1:0]        tc_q, tc_d, tr_q, tr_d, ofm_q, ofm_d;
    logic [CHN_WIDTH-1:0] chi_q, chi_d, cho_q, cho_d;
    logic                 s2_q, s2_d, k3_q, k3_d;
    logic [PV_LAT-1:0]    pv_q, pv_d;
    logic                 busy_q, busy_d, cfg_err_q, cfg_err_d;

    logic          start_ok, cfg_bad, accept, cnt_valid;
    logic          pc_last, ic_last, oc_last, tc_last, tr_last;
    logic [FW-1:0] tw_m1, ofm_m1, ntc_m1, ntr_m1, rem, width_m1, ifm_sub, ifm_diff;

    // Tile geometry from the latched config; the last column tile may be narrow.
    always_comb begin
        tw_m1    = s2_q ? FW'(TILE_LEN / 2 - 1) : FW'(TILE_LEN - 1);
        ofm_m1   = ofm_q - FW'(1);
        ntc_m1   = s2_q ? (ofm_m1 >> (TL_LG - 1)) : (ofm_m1 >> TL_LG);
        ntr_m1   = s2_q ? (ofm_m1 >> (TR_LG - 1)) : (ofm_m1 >> TR_LG);
        rem      = ofm_q & tw_m1;
        width_m1 = ((tc_q == ntc_m1) && (rem != '0)) ? rem - FW'(1) : tw_m1;
        pc_last  = (FW'(pc_q) == width_m1);
        ic_last  = (ic_q == (ICW'(chi_q) << CHN_OFT_WIDTH) - ICW'(1));
        oc_last  = (oc_q == (ICW'(cho_q) << CHN_OFT_WIDTH) - ICW'(1));
        tc_last  = (tc_q == ntc_m1);
        tr_last  = (tr_q == ntr_m1);
    end

    always_comb begin
        cfg_bad   = (chi == '0) || (cho == '0) || (ksize && (ifm_size < FW'(3)));
        start_ok  = start_conv && (state_q == S_IDLE) && !abort;
        accept    = start_ok && !cfg_bad;
        cnt_valid = (state_q == S_CALC) && out_ready && !abort;
        ic_done   = cnt_valid && pc_last;
        oc_done   = ic_done && ic_last;
        tile_done = oc_done && oc_last;
        conv_done = tile_done && tc_last && tr_last;
        ifm_read  = (state_q == S_FLUSH) || ((state_q == S_CALC) && out_ready);
        wgt_read  = (state_q == S_FLUSH) && (fc_q < (k3_q ? FCW'(3) : FCW'(1)));
        ifm_sub   = ksize ? FW'(3) : FW'(1);
        ifm_diff  = ifm_size - ifm_sub;
    end

    always_comb begin
        state_d   = state_q;
        fc_d      = fc_q;
        pc_d      = pc_q;
        ic_d      = ic_q;
        oc_d      = oc_q;
        tc_d      = tc_q;
        tr_d      = tr_q;
        ofm_d     = ofm_q;
        chi_d     = chi_q;
        cho_d     = cho_q;
        s2_d      = s2_q;
        k3_d      = k3_q;
        pv_d      = PV_LAT'({pv_q, cnt_valid});
        cfg_err_d = start_ok && cfg_bad;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FLUSH;
                    fc_d    = '0;
                    pc_d    = '0;
                    ic_d    = '0;
                    oc_d    = '0;
                    tc_d    = '0;
                    tr_d    = '0;
                    chi_d   = chi;
                    cho_d   = cho;
                    s2_d    = stride;
                    k3_d    = ksize;
                    ofm_d   = stride ? (ifm_diff >> 1) + FW'(1) : ifm_diff + FW'(1);
                end
            end
            S_FLUSH: begin
                if (fc_q == FCW'(FLUSH_LAT - 1)) begin
                    state_d = S_CALC;
                    fc_d    = '0;
                end else begin
                    fc_d = fc_q + FCW'(1);
                end
            end
            S_CALC: begin
                // Each loop level wraps when it completes and carries into the next.
                if (cnt_valid) begin
                    pc_d = pc_last ? '0 : pc_q + PCW'(1);
                    if (pc_last) begin
                        ic_d = ic_last ? '0 : ic_q + ICW'(1);
                        if (ic_last) begin
                            oc_d = oc_last ? '0 : oc_q + ICW'(1);
                            if (oc_last) begin
                                tc_d = tc_last ? '0 : tc_q + FW'(1);
                                if (tc_last) begin
                                    tr_d = tr_last ? '0 : tr_q + FW'(1);
                                end
                            end
                        end
                    end
                    if (conv_done) begin
                        state_d = S_IDLE;
                    end else if (ic_done) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            fc_d    = '0;
            pc_d    = '0;
            ic_d    = '0;
            oc_d    = '0;
            tc_d    = '0;
            tr_d    = '0;
            pv_d    = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            fc_q      <= '0;
            pc_q      <= '0;
            ic_q      <= '0;
            oc_q      <= '0;
            tc_q      <= '0;
            tr_q      <= '0;
            ofm_q     <= '0;
            chi_q     <= '0;
            cho_q     <= '0;
            s2_q      <= 1'b0;
            k3_q      <= 1'b0;
            pv_q      <= '0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fc_q      <= fc_d;
            pc_q      <= pc_d;
            ic_q      <= ic_d;
            oc_q      <= oc_d;
            tc_q      <= tc_d;
            tr_q      <= tr_d;
            ofm_q     <= ofm_d;
            chi_q     <= chi_d;
            cho_q     <= cho_d;
            s2_q      <= s2_d;
            k3_q      <= k3_d;
            pv_q      <= pv_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign busy    = busy_q;
    assign cfg_err = cfg_err_q;
    assign pvalid  = pv_q[PV_LAT-1];

`ifdef PEA_TILE_SCHED_PERF_EN
    logic [PERF_WIDTH-1:0] pcyc_q, pcyc_d, pstl_q, pstl_d;

    // Saturating busy/stall counters, cleared when a job is accepted.
    always_comb begin
        pcyc_d = pcyc_q;
        pstl_d = pstl_q;
        if (accept) begin
            pcyc_d = '0;
            pstl_d = '0;
        end else begin
            if ((state_q != S_IDLE) && (pcyc_q != '1)) begin
                pcyc_d = pcyc_q + PERF_WIDTH'(1);
            end
            if ((state_q == S_CALC) && !out_ready && (pstl_q != '1)) begin
                pstl_d = pstl_q + PERF_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcyc_q <= '0;
            pstl_q <= '0;
        end else begin
            pcyc_q <= pcyc_d;
            pstl_q <= pstl_d;
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_stalls = pstl_q;
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_pea_tile_sched.sv
// Bench for pea_tile_sched: job-level loop-nest model checked every cycle, plus literal totals per job.
module tb_pea_tile_sched;

    localparam int TILE_LEN   = 16;
    localparam int TILE_ROWS  = 8;
    localparam int CHN_WIDTH  = 4;
    localparam int CHN_OFT    = 2;
    localparam int FMS_WIDTH  = 8;
    localparam int FLUSH_LAT  = 5;
    localparam int PV_LAT     = 3;
    localparam int PERF_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [CHN_WIDTH-1:0]  chi, cho;
    logic                  stride, ksize, start_conv, abort, out_ready;
    logic [FMS_WIDTH-1:0]  ifm_size;
    logic                  ifm_read, wgt_read, pvalid, ic_done, oc_done, tile_done, conv_done;
    logic                  busy, cfg_err;
    logic [PERF_WIDTH-1:0] perf_cycles, perf_stalls;

    pea_tile_sched #(
        .TILE_LEN(TILE_LEN), .TILE_ROWS(TILE_ROWS), .CHN_WIDTH(CHN_WIDTH),
        .CHN_OFT_WIDTH(CHN_OFT), .FMS_WIDTH(FMS_WIDTH), .FLUSH_LAT(FLUSH_LAT),
        .PV_LAT(PV_LAT), .PERF_WIDTH(PERF_WIDTH)
    ) dut (
        .clk(clk), .rstn(rstn), .chi(chi), .cho(cho), .stride(stride), .ksize(ksize),
        .ifm_size(ifm_size), .start_conv(start_conv), .abort(abort), .out_ready(out_ready),
        .ifm_read(ifm_read), .wgt_read(wgt_read), .pvalid(pvalid), .ic_done(ic_done),
        .oc_done(oc_done), .tile_done(tile_done), .conv_done(conv_done), .busy(busy),
        .cfg_err(cfg_err), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ic;
        logic oc;
        logic tile;
        logic conv;
    } step_t;

    step_t             m_q[$];
    int                m_mode = 0;   // 0 idle, 1 flush, 2 calc
    int                m_fidx = 0;
    bit                m_k3 = 0;
    logic [PV_LAT-1:0] m_pv = '0;
    bit                m_cfg_pend = 0;

    int vectors = 0, miscompares = 0;
    int cyc = 0, start_cyc = 0, first_pv_cyc = -1;
    int n_ic = 0, n_oc = 0, n_tile = 0, n_conv = 0, n_pv = 0;

    step_t st;
    bit    cv, e_busy, e_ifm, e_wgt, e_pv, e_cfg;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Flatten the whole job into one entry per pixel step, flagging which loops complete there.
    function automatic void build_job(input int ci, input int co, input int ifm,
                                      input bit s2, input bit k3);
        int ofm, tw, th, ntc, ntr, lw, w, nci, nco;
        step_t s;
        ofm = k3 ? (s2 ? (ifm - 3) / 2 + 1 : ifm - 2) : (s2 ? (ifm - 1) / 2 + 1 : ifm);
        tw  = s2 ? TILE_LEN / 2 : TILE_LEN;
        th  = s2 ? TILE_ROWS / 2 : TILE_ROWS;
        ntc = (ofm + tw - 1) / tw;
        ntr = (ofm + th - 1) / th;
        lw  = (ofm % tw == 0) ? tw : ofm % tw;
        nci = ci * (1 << CHN_OFT);
        nco = co * (1 << CHN_OFT);
        m_q.delete();
        for (int r = 0; r < ntr; r++)
            for (int t = 0; t < ntc; t++) begin
                w = (t == ntc - 1) ? lw : tw;
                for (int o = 0; o < nco; o++)
                    for (int i = 0; i < nci; i++)
                        for (int p = 0; p < w; p++) begin
                            s.ic   = (p == w - 1);
                            s.oc   = s.ic && (i == nci - 1);
                            s.tile = s.oc && (o == nco - 1);
                            s.conv = s.tile && (t == ntc - 1) && (r == ntr - 1);
                            m_q.push_back(s);
                        end
            end
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            m_mode = 0; m_fidx = 0; m_pv = '0; m_cfg_pend = 0;
            m_q.delete();
        end else begin
            cyc++;
            st = '0;
            cv = (m_mode == 2) && out_ready && !abort;
            if (cv && m_q.size() > 0) st = m_q[0];
            e_busy = (m_mode != 0);
            e_ifm  = (m_mode == 1) || ((m_mode == 2) && out_ready);
            e_wgt  = (m_mode == 1) && (m_fidx < (m_k3 ? 3 : 1));
            e_pv   = m_pv[PV_LAT-1];
            e_cfg  = m_cfg_pend;
            chk("busy", int'(busy), int'(e_busy));
            chk("ifm_read", int'(ifm_read), int'(e_ifm));
            chk("wgt_read", int'(wgt_read), int'(e_wgt));
            chk("pvalid", int'(pvalid), int'(e_pv));
            chk("ic_done", int'(ic_done), int'(st.ic));
            chk("oc_done", int'(oc_done), int'(st.oc));
            chk("tile_done", int'(tile_done), int'(st.tile));
            chk("conv_done", int'(conv_done), int'(st.conv));
            chk("cfg_err", int'(cfg_err), int'(e_cfg));
            if (pvalid && first_pv_cyc < 0) first_pv_cyc = cyc;
            n_ic   += int'(ic_done);
            n_oc   += int'(oc_done);
            n_tile += int'(tile_done);
            n_conv += int'(conv_done);
            n_pv   += int'(pvalid);
            m_cfg_pend = 0;
            if (abort) begin
                m_mode = 0;
                m_q.delete();
                m_pv = '0;
            end else begin
                m_pv = {m_pv[PV_LAT-2:0], cv};
                case (m_mode)
                    0: if (start_conv) begin
                        if (chi == 0 || cho == 0 || (ksize && ifm_size < 3)) begin
                            m_cfg_pend = 1;
                        end else begin
                            build_job(int'(chi), int'(cho), int'(ifm_size), stride, ksize);
                            m_k3 = ksize;
                            m_mode = 1;
                            m_fidx = 0;
                            start_cyc = cyc;
                            first_pv_cyc = -1;
                        end
                    end
                    1: begin
                        m_fidx++;
                        if (m_fidx == FLUSH_LAT) m_mode = 2;
                    end
                    default: if (cv) begin
                        void'(m_q.pop_front());
                        if (st.conv) m_mode = 0;
                        else if (st.ic) begin
                            m_mode = 1;
                            m_fidx = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic start_pulse(input int ci, input int co, input int ifm, input bit s2, input bit k3);
        chi = CHN_WIDTH'(ci); cho = CHN_WIDTH'(co); ifm_size = FMS_WIDTH'(ifm);
        stride = s2; ksize = k3; start_conv = 1'b1;
        @(posedge clk); #1;
        start_conv = 1'b0;
    endtask

    task automatic run_job(input int ci, input int co, input int ifm, input bit s2, input bit k3,
                           input int stall_at, input int poke_at,
                           input int e_ic, input int e_oc, input int e_tile, input int e_npv,
                           input string tag);
        int c, b_ic, b_oc, b_tile, b_conv, b_pv;
        b_ic = n_ic; b_oc = n_oc; b_tile = n_tile; b_conv = n_conv; b_pv = n_pv;
        start_pulse(ci, co, ifm, s2, k3);
        c = 1;
        while (c < 20000) begin
            if (!busy) break;
            if (stall_at > 0 && c == stall_at) out_ready = 1'b0;
            if (stall_at > 0 && c == stall_at + 4) out_ready = 1'b1;
            if (poke_at > 0 && c == poke_at) begin
                start_conv = 1'b1; chi = 4'd3; ifm_size = 8'd37;
            end
            if (poke_at > 0 && c == poke_at + 1) begin
                start_conv = 1'b0; chi = CHN_WIDTH'(ci); ifm_size = FMS_WIDTH'(ifm);
            end
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_finished"}, int'(busy), 0);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk({tag, "_ic_total"}, n_ic - b_ic, e_ic);
        chk({tag, "_oc_total"}, n_oc - b_oc, e_oc);
        chk({tag, "_tile_total"}, n_tile - b_tile, e_tile);
        chk({tag, "_conv_total"}, n_conv - b_conv, 1);
        chk({tag, "_pvalid_total"}, n_pv - b_pv, e_npv);
        chk({tag, "_first_pvalid"}, first_pv_cyc - start_cyc, FLUSH_LAT + 1 + PV_LAT);
`ifdef PEA_TILE_SCHED_PERF_EN
        chk({tag, "_perf_cycles"}, int'(perf_cycles), e_npv + e_ic * FLUSH_LAT + (stall_at > 0 ? 4 : 0));
        chk({tag, "_perf_stalls"}, int'(perf_stalls), (stall_at > 0) ? 4 : 0);
`else
        chk({tag, "_perf_cycles"}, int'(perf_cycles), 0);
        chk({tag, "_perf_stalls"}, int'(perf_stalls), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int b_conv;
        rstn = 1'b0; start_conv = 1'b0; abort = 1'b0; out_ready = 1'b1;
        chi = '0; cho = '0; stride = 1'b0; ksize = 1'b0; ifm_size = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_pvalid", int'(pvalid), 0);
        chk("reset_ifm_read", int'(ifm_read), 0);
        chk("reset_wgt_read", int'(wgt_read), 0);
        chk("reset_conv_done", int'(conv_done), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        chk("reset_perf_cycles", int'(perf_cycles), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 4 input and 4 output channels per group with CHN_OFT = 2
        run_job(1, 1, 10, 1'b0, 1'b1, 0, 0, 16, 4, 1, 128, "k3s1_ifm10");
        run_job(1, 1, 37, 1'b0, 1'b1, 0, 0, 240, 60, 15, 2800, "k3s1_ifm37");
        run_job(1, 1, 35, 1'b1, 1'b1, 0, 0, 240, 60, 15, 1360, "k3s2_ifm35");
        run_job(2, 3, 5, 1'b1, 1'b0, 0, 0, 96, 12, 1, 288, "k1s2_groups");
        run_job(1, 1, 16, 1'b0, 1'b0, 0, 0, 32, 8, 2, 512, "k1s1_ifm16");
        run_job(1, 1, 17, 1'b0, 1'b0, 0, 0, 96, 24, 6, 816, "k1s1_ifm17");
        run_job(1, 1, 3, 1'b0, 1'b1, 0, 0, 16, 4, 1, 16, "k3s1_ifm3");
        run_job(1, 1, 2, 1'b0, 1'b0, 0, 0, 16, 4, 1, 32, "k1s1_ifm2");
        run_job(1, 1, 10, 1'b0, 1'b1, 8, 0, 16, 4, 1, 128, "stall");
        run_job(1, 1, 10, 1'b0, 1'b1, 0, 10, 16, 4, 1, 128, "start_while_busy");

        // abort in the third FLUSH cycle
        b_conv = n_conv;
        start_pulse(1, 1, 10, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("abort_no_conv", n_conv - b_conv, 0);
        run_job(1, 1, 10, 1'b0, 1'b1, 0, 0, 16, 4, 1, 128, "after_abort");

        // start and abort together: start dropped
        chi = 4'd1; cho = 4'd1; ifm_size = 8'd10; ksize = 1'b1; stride = 1'b0;
        start_conv = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start_conv = 1'b0; abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_cfg_err", int'(cfg_err), 0);

        // rejected configurations
        start_pulse(0, 1, 10, 1'b0, 1'b1);
        chk("chi0_cfg_err", int'(cfg_err), 1);
        chk("chi0_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("chi0_cfg_err_pulse", int'(cfg_err), 0);
        start_pulse(1, 1, 2, 1'b0, 1'b1);
        chk("k3_ifm2_cfg_err", int'(cfg_err), 1);
        chk("k3_ifm2_busy", int'(busy), 0);
        start_pulse(1, 0, 10, 1'b0, 1'b0);
        chk("cho0_cfg_err", int'(cfg_err), 1);
        repeat (3) begin
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
